// File: rtl/mul_3_seq.sv
// rtl/mul_3_seq.sv - iterative shift-add multiplier, signed WIDTH-bit operand times constant FACTOR
// Define MUL_3_SEQ_SAT_EN to saturate the result on overflow; otherwise it wraps.
module mul_3_seq #(
  parameter int WIDTH    = 8,
  parameter int FACTOR   = 3,
  parameter int FACTOR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);

  localparam int AW    = 2 * WIDTH;
  localparam int CNT_W = (FACTOR_W > 1) ? $clog2(FACTOR_W) : 1;
  localparam logic [FACTOR_W-1:0] FACTOR_V = FACTOR[FACTOR_W-1:0];
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(FACTOR_W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       mcand_q, mcand_d;
  logic [FACTOR_W-1:0] mreg_q, mreg_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic [AW-1:0]       acc_nx;
  logic                ovf_nx;
  logic [WIDTH-1:0]    fit_nx;

  // The product fits in the top WIDTH+1 bits agreeing; any disagreement means
  // the value lies outside the signed WIDTH-bit range.
  always_comb begin
    acc_nx = acc_q + (mreg_q[0] ? mcand_q : '0);
    ovf_nx = !((&acc_nx[AW-1:WIDTH-1]) || !(|acc_nx[AW-1:WIDTH-1]));
`ifdef MUL_3_SEQ_SAT_EN
    if (ovf_nx) begin
      fit_nx = acc_nx[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      fit_nx = acc_nx[WIDTH-1:0];
    end
`else
    fit_nx = acc_nx[WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mreg_d  = mreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_d = {{WIDTH{in[WIDTH-1]}}, in};
            mreg_d  = FACTOR_V;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          mcand_d = mcand_q << 1;
          mreg_d  = mreg_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            out_d   = fit_nx;
            ovf_d   = ovf_nx;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            acc_d = acc_nx;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mreg_q  <= mreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign done = done_q;
  assign out  = out_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mul_3_seq.sv
// tb/tb_mul_3_seq.sv - self-checking bench for mul_3_seq against an arithmetic reference model
module tb_mul_3_seq;

  localparam int WIDTH    = 8;
  localparam int FACTOR   = 3;
  localparam int FACTOR_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] in_s = '0;
  logic             busy, done, ovf;
  logic [WIDTH-1:0] out_s;

  int n_asserts = 0;
  int n_fails   = 0;
  int prev_out  = 0;

  mul_3_seq #(.WIDTH(WIDTH), .FACTOR(FACTOR), .FACTOR_W(FACTOR_W)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .in(in_s),
    .busy(busy), .done(done), .out(out_s), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact product, range test, then wrap or clamp to WIDTH bits.
  task automatic model(input int v, output int o, output int ov);
    int p;
    logic [31:0] pb;
    p  = v * FACTOR;
    ov = (p > 127 || p < -128) ? 1 : 0;
`ifdef MUL_3_SEQ_SAT_EN
    if (ov != 0) o = (p > 0) ? 127 : -128;
    else o = p;
`else
    pb = p;
    o  = $signed(pb[7:0]);
`endif
  endtask

  task automatic run_op(input string tag, input int v, input int lo_at, input int lo_n);
    int eo, eov, k, busy_cnt;
    bit seen;
    model(v, eo, eov);
    @(negedge clk);
    start = 1'b1; in_s = v[WIDTH-1:0]; en = 1'b1;
    @(negedge clk);
    start = 1'b0; in_s = $urandom;
    chk({tag, "_busy_after_accept"}, busy, 1);
    busy_cnt = busy ? 1 : 0;
    k = 0; seen = 0;
    while (!seen && k < 40) begin
      en = (k >= lo_at && k < lo_at + lo_n) ? 1'b0 : 1'b1;
      @(negedge clk);
      k++;
      if (!en) chk({tag, "_out_frozen"}, $signed(out_s), prev_out);
      if (done) seen = 1;
      else if (busy) busy_cnt++;
    end
    en = 1'b1;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, k, FACTOR_W + lo_n);
    chk({tag, "_out"}, $signed(out_s), eo);
    chk({tag, "_ovf"}, ovf, eov);
    chk({tag, "_busy_cycles"}, busy_cnt, FACTOR_W + lo_n);
    chk({tag, "_busy_low_at_done"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_out_hold"}, $signed(out_s), eo);
    prev_out = eo;
  endtask

  initial begin
    int eo, eov, t, d1, d2, o1, o2, lo_at, lo_n, v;
    bit extra;

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out", $signed(out_s), 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;

    // Directed values, including range boundaries
    run_op("p42", 42, 99, 0);
    run_op("m42", -42, 99, 0);
    run_op("zero", 0, 99, 0);
    run_op("m128", -128, 99, 0);
    run_op("p50", 50, 99, 0);
    run_op("m50", -50, 99, 0);
    run_op("p127", 127, 99, 0);
    run_op("p43", 43, 99, 0);
    run_op("m43", -43, 99, 0);
    run_op("en_low", 42, 1, 3);

    // start held high: second request accepted the cycle after done
    @(negedge clk);
    start = 1'b1; in_s = 8'd10;
    @(negedge clk);
    in_s = 8'd20;
    d1 = -1; d2 = -1; o1 = 0; o2 = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c > FACTOR_W) in_s = $urandom;
      if (done && d1 < 0) begin d1 = c; o1 = $signed(out_s); end
      else if (done && d2 < 0) begin d2 = c; o2 = $signed(out_s); start = 1'b0; end
    end
    start = 1'b0;
    chk("hold_start_first_at", d1, FACTOR_W);
    chk("hold_start_first_out", o1, 30);
    chk("hold_start_spacing", d2 - d1, FACTOR_W + 1);
    chk("hold_start_second_out", o2, 60);
    repeat (12) @(negedge clk);
    prev_out = $signed(out_s);
    chk("hold_start_idle", busy, 0);

    // Reset mid-operation aborts with no done
    @(negedge clk);
    start = 1'b1; in_s = 8'd33;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out", $signed(out_s), 0);
    chk("abort_ovf", ovf, 0);
    rst = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) extra = 1;
    end
    chk("abort_no_done", extra, 0);
    prev_out = 0;
    run_op("after_abort", 7, 99, 0);

    // Randomized operands and enable gaps
    for (int i = 0; i < 24; i++) begin
      v     = $signed(8'($urandom));
      lo_n  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      lo_at = $urandom_range(0, FACTOR_W - 1);
      run_op("rand", v, lo_at, lo_n);
    end

    t = 0;
    model(-128, eo, eov);
    chk("model_sanity_m128", eo, -128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
